// File: rtl/branch_metric_if.sv
`timescale 1ns/1ps
// branch_metric_if
// Bundles the control, slicer-side and decoder-side signals of branch_metric.
//   en_bm        control enable; low returns the block to IDLE
//   i_code_rate  `CODE_RATE_2 (rate 1/2) or `CODE_RATE_3 (rate 1/3)
//   i_rx         sliced symbol pair, sym0 = i_rx[2:0], sym1 = i_rx[5:3]
//   i_valid      i_rx carries a real pair this cycle
//   i_ood        end-of-data marker from the slicer
//   o_bm0/o_bm1  packed Hamming metrics, entry c at [BM_WIDTH*c +: BM_WIDTH]
//   o_valid      o_bm0/o_bm1 hold a metric pair this cycle
//   o_last       final pair (or bare end marker) of the frame
//   o_done       frame complete, held until en_bm drops
//   o_pair_cnt   pairs issued in the current frame, saturating at 255
// master = the side driving the slicer inputs, slave = branch_metric.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

interface branch_metric_if #(
    parameter int SLICED_INPUT_NUM = 6,
    parameter int BM_WIDTH         = 2
);
    logic                        en_bm;
    logic                        i_code_rate;
    logic [SLICED_INPUT_NUM-1:0] i_rx;
    logic                        i_valid;
    logic                        i_ood;
    logic [8*BM_WIDTH-1:0]       o_bm0;
    logic [8*BM_WIDTH-1:0]       o_bm1;
    logic                        o_valid;
    logic                        o_last;
    logic                        o_done;
    logic [7:0]                  o_pair_cnt;

    modport master (
        output en_bm, i_code_rate, i_rx, i_valid, i_ood,
        input  o_bm0, o_bm1, o_valid, o_last, o_done, o_pair_cnt
    );

    modport slave (
        input  en_bm, i_code_rate, i_rx, i_valid, i_ood,
        output o_bm0, o_bm1, o_valid, o_last, o_done, o_pair_cnt
    );
endinterface

// File: rtl/branch_metric.sv
`timescale 1ns/1ps
// branch_metric
// Computes Hamming-distance branch metrics for a pair of sliced 3-bit
// received symbols against all eight codewords, for rate 1/2 (2-bit
// codewords, entries 4..7 forced to zero) or rate 1/3 (3-bit codewords).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        branch_metric_if.slave (control, symbol input, metric output)
//   dbg_state  current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: i_valid and o_valid are pure qualifiers with no ready. In RUN
// the block accepts every i_valid pair; each accepted pair appears exactly
// two cycles later with o_valid, one pair per cycle, and the consumer must
// take every o_valid pair on the cycle it is presented.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module branch_metric #(
    parameter int SLICED_INPUT_NUM = 6,
    parameter int BM_WIDTH         = 2
) (
    input  logic                clk,
    input  logic                rst,
    branch_metric_if.slave      bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic                        drain_cnt;
    logic                        rate_q;
    logic                        s1_valid;
    logic                        s1_last;
    logic [SLICED_INPUT_NUM-1:0] s1_rx;
    logic                        accept;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Rate 1/2 compares only sym[1:0] against the four 2-bit codewords.
    function automatic logic [8*BM_WIDTH-1:0] metrics(input logic [2:0] sym,
                                                      input logic       rate3);
        logic [8*BM_WIDTH-1:0] m;
        logic [2:0]            d;
        m = '0;
        for (int c = 0; c < 8; c++) begin
            d = sym ^ 3'(c);
            if (rate3)
                m[BM_WIDTH*c +: BM_WIDTH] = BM_WIDTH'(popcnt3(d));
            else if (c < 4)
                m[BM_WIDTH*c +: BM_WIDTH] = BM_WIDTH'(popcnt3({1'b0, d[1:0]}));
        end
        return m;
    endfunction

    assign accept    = (state == RUN) && bus.i_valid;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            drain_cnt      <= 1'b0;
            rate_q         <= 1'b0;
            s1_valid       <= 1'b0;
            s1_last        <= 1'b0;
            s1_rx          <= '0;
            bus.o_bm0      <= '0;
            bus.o_bm1      <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_last     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_pair_cnt <= 8'd0;
        end else if (!bus.en_bm) begin
            // Dropping enable abandons the frame: flush everything in flight.
            state          <= IDLE;
            drain_cnt      <= 1'b0;
            s1_valid       <= 1'b0;
            s1_last        <= 1'b0;
            s1_rx          <= '0;
            bus.o_bm0      <= '0;
            bus.o_bm1      <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_last     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_pair_cnt <= 8'd0;
        end else begin
            // Stage 1: capture the pair and its end marker.
            s1_valid <= accept;
            s1_last  <= (state == RUN) && bus.i_ood;
            s1_rx    <= accept ? bus.i_rx : '0;

            // Stage 2: metrics use the rate latched at frame start, and read
            // as zero whenever no pair is presented.
            bus.o_valid <= s1_valid;
            bus.o_last  <= s1_last;
            bus.o_bm0   <= s1_valid ? metrics(s1_rx[2:0], rate_q == `CODE_RATE_3) : '0;
            bus.o_bm1   <= s1_valid ? metrics(s1_rx[5:3], rate_q == `CODE_RATE_3) : '0;
            if (s1_valid && (bus.o_pair_cnt != 8'hFF))
                bus.o_pair_cnt <= bus.o_pair_cnt + 8'd1;

            case (state)
                IDLE: begin
                    rate_q         <= bus.i_code_rate;
                    bus.o_pair_cnt <= 8'd0;
                    state          <= RUN;
                end
                RUN: begin
                    if (bus.i_ood) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Two cycles lets the last pair leave stage 2 before DONE.
                    if (drain_cnt) begin
                        state      <= DONE;
                        bus.o_done <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    bus.o_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_metric.sv
`timescale 1ns/1ps
// tb_branch_metric
// Directed bench for branch_metric: reset values, rate 1/2 and rate 1/3
// metrics, back-to-back frame with end marker, rate toggling and counter
// saturation, mid-frame reset and enable drop.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_branch_metric;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;
    int         checks   = 0;
    int         failures = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    branch_metric_if #(.SLICED_INPUT_NUM(6), .BM_WIDTH(2)) bus ();

    branch_metric #(.SLICED_INPUT_NUM(6), .BM_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Pack eight hand-computed 2-bit metrics, entry 0 in the low bits.
    function automatic logic [15:0] pk(input int e0, input int e1, input int e2, input int e3,
                                       input int e4, input int e5, input int e6, input int e7);
        logic [15:0] r;
        r = {2'(e7), 2'(e6), 2'(e5), 2'(e4), 2'(e3), 2'(e2), 2'(e1), 2'(e0)};
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic rate);
        bus.en_bm       = 1'b1;
        bus.i_code_rate = rate;
        bus.i_valid     = 1'b0;
        bus.i_ood       = 1'b0;
        bus.i_rx        = '0;
        tick();
    endtask

    task automatic end_frame();
        bus.en_bm   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ood   = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.en_bm = 1'b0; bus.i_code_rate = 1'b0; bus.i_rx = '0;
        bus.i_valid = 1'b0; bus.i_ood = 1'b0;
        rst = 1'b0;
        #12;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%0b exp=0", bus.o_last); end
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.o_done); end
        checks++; if (bus.o_bm0 !== 16'h0) begin failures++; $display("FAIL rst_bm0 got=%0h exp=0", bus.o_bm0); end
        checks++; if (bus.o_bm1 !== 16'h0) begin failures++; $display("FAIL rst_bm1 got=%0h exp=0", bus.o_bm1); end
        checks++; if (bus.o_pair_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", bus.o_pair_cnt); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        rst = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_rate2();
        start_frame(`CODE_RATE_2);
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL r2_run got=%0d exp=1", dbg_state); end
        bus.i_valid = 1'b1; bus.i_rx = 6'b000_011;
        tick();
        bus.i_valid = 1'b0; bus.i_rx = '0;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL r2_early got=%0b exp=0", bus.o_valid); end
        tick();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL r2_valid got=%0b exp=1", bus.o_valid); end
        checks++; if (bus.o_bm0 !== pk(2,1,1,0,0,0,0,0)) begin failures++; $display("FAIL r2_bm0 got=%0h exp=%0h", bus.o_bm0, pk(2,1,1,0,0,0,0,0)); end
        checks++; if (bus.o_bm1 !== pk(0,1,1,2,0,0,0,0)) begin failures++; $display("FAIL r2_bm1 got=%0h exp=%0h", bus.o_bm1, pk(0,1,1,2,0,0,0,0)); end
        checks++; if (bus.o_pair_cnt !== 8'd1) begin failures++; $display("FAIL r2_cnt1 got=%0d exp=1", bus.o_pair_cnt); end
        // bit 2 of each symbol must be ignored at rate 1/2
        bus.i_valid = 1'b1; bus.i_rx = 6'b111_100;
        tick();
        bus.i_valid = 1'b0; bus.i_rx = '0;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL r2_gap got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_bm0 !== 16'h0) begin failures++; $display("FAIL r2_zero got=%0h exp=0", bus.o_bm0); end
        tick();
        checks++; if (bus.o_bm0 !== pk(0,1,1,2,0,0,0,0)) begin failures++; $display("FAIL r2b_bm0 got=%0h exp=%0h", bus.o_bm0, pk(0,1,1,2,0,0,0,0)); end
        checks++; if (bus.o_bm1 !== pk(2,1,1,0,0,0,0,0)) begin failures++; $display("FAIL r2b_bm1 got=%0h exp=%0h", bus.o_bm1, pk(2,1,1,0,0,0,0,0)); end
        checks++; if (bus.o_pair_cnt !== 8'd2) begin failures++; $display("FAIL r2_cnt2 got=%0d exp=2", bus.o_pair_cnt); end
        // end marker without a pair: o_last alone two cycles later
        bus.i_ood = 1'b1;
        tick();
        bus.i_ood = 1'b0;
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL ood_early got=%0b exp=0", bus.o_last); end
        tick();
        checks++; if (bus.o_last !== 1'b1) begin failures++; $display("FAIL ood_last got=%0b exp=1", bus.o_last); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL ood_valid got=%0b exp=0", bus.o_valid); end
        tick();
        checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL ood_done got=%0b exp=1", bus.o_done); end
        checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL ood_last_drop got=%0b exp=0", bus.o_last); end
        checks++; if (dbg_state !== 2'd3) begin failures++; $display("FAIL ood_state got=%0d exp=3", dbg_state); end
        end_frame();
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL r2_done_clr got=%0b exp=0", bus.o_done); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL r2_idle got=%0d exp=0", dbg_state); end
        checks++; if (bus.o_pair_cnt !== 8'd0) begin failures++; $display("FAIL r2_cnt_clr got=%0d exp=0", bus.o_pair_cnt); end
    endtask

    task automatic test_rate3();
        start_frame(`CODE_RATE_3);
        // sym0 = 3'b111, sym1 = 3'b101
        bus.i_valid = 1'b1; bus.i_rx = 6'b101_111;
        tick();
        bus.i_valid = 1'b0;
        bus.i_code_rate = `CODE_RATE_2;
        tick();
        checks++; if (bus.o_bm0 !== pk(3,2,2,1,2,1,1,0)) begin failures++; $display("FAIL r3_bm0 got=%0h exp=%0h", bus.o_bm0, pk(3,2,2,1,2,1,1,0)); end
        checks++; if (bus.o_bm1 !== pk(2,1,3,2,1,0,2,1)) begin failures++; $display("FAIL r3_bm1 got=%0h exp=%0h", bus.o_bm1, pk(2,1,3,2,1,0,2,1)); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  rx_tab[4];
        logic [15:0] e0_tab[4];
        logic [15:0] e1_tab[4];
        logic [15:0] e0, e1;
        logic [7:0]  exp_cnt;
        rx_tab = '{6'b000_000, 6'b111_001, 6'b010_100, 6'b110_011};
        e0_tab = '{pk(0,1,1,2,1,2,2,3), pk(1,0,2,1,2,1,3,2), pk(1,2,2,3,0,1,1,2), pk(2,1,1,0,3,2,2,1)};
        e1_tab = '{pk(0,1,1,2,1,2,2,3), pk(3,2,2,1,2,1,1,0), pk(1,2,0,1,2,3,1,2), pk(2,3,1,2,1,2,0,1)};
        start_frame(`CODE_RATE_3);
        for (int cyc = 0; cyc < 8; cyc++) begin
            // pairs keep coming through DRAIN and DONE and must be dropped
            bus.i_valid = (cyc <= 6);
            bus.i_rx    = (cyc < 4) ? rx_tab[cyc] : 6'b111_111;
            bus.i_ood   = (cyc == 3);
            if (cyc < 4) begin
                exp_q0.push_back(e0_tab[cyc]);
                exp_q1.push_back(e1_tab[cyc]);
            end
            tick();
            exp_cnt = (cyc < 1) ? 8'd0 : (cyc <= 4) ? 8'(cyc) : 8'd4;
            checks++; if (bus.o_valid !== ((cyc >= 1) && (cyc <= 4))) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%0b", cyc, bus.o_valid); end
            if (bus.o_valid === 1'b1 && exp_q0.size() > 0) begin
                e0 = exp_q0.pop_front();
                e1 = exp_q1.pop_front();
                checks++; if (bus.o_bm0 !== e0) begin failures++; $display("FAIL b2b_bm0 cyc=%0d got=%0h exp=%0h", cyc, bus.o_bm0, e0); end
                checks++; if (bus.o_bm1 !== e1) begin failures++; $display("FAIL b2b_bm1 cyc=%0d got=%0h exp=%0h", cyc, bus.o_bm1, e1); end
            end else begin
                checks++; if (bus.o_bm0 !== 16'h0 || bus.o_bm1 !== 16'h0) begin failures++; $display("FAIL b2b_zero cyc=%0d got=%0h/%0h exp=0", cyc, bus.o_bm0, bus.o_bm1); end
            end
            checks++; if (bus.o_last !== (cyc == 4)) begin failures++; $display("FAIL b2b_last cyc=%0d got=%0b", cyc, bus.o_last); end
            checks++; if (bus.o_done !== (cyc >= 5)) begin failures++; $display("FAIL b2b_done cyc=%0d got=%0b", cyc, bus.o_done); end
            checks++; if (bus.o_pair_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.o_pair_cnt, exp_cnt); end
        end
        checks++; if (exp_q0.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d exp=0", exp_q0.size()); end
        exp_q0.delete();
        exp_q1.delete();
        end_frame();
        checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL b2b_done_clr got=%0b exp=0", bus.o_done); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL b2b_idle got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_toggle_saturate();
        int n_out;
        logic [7:0] exp_cnt;
        n_out = 0;
        start_frame(`CODE_RATE_2);
        for (int cyc = 0; cyc < 302; cyc++) begin
            bus.i_valid     = (cyc < 300);
            bus.i_rx        = 6'b111_111;
            bus.i_code_rate = cyc[0];
            tick();
            if (bus.o_valid === 1'b1) begin
                n_out++;
                checks++; if (bus.o_bm0 !== pk(2,1,1,0,0,0,0,0) || bus.o_bm1 !== pk(2,1,1,0,0,0,0,0)) begin failures++; $display("FAIL tog_bm cyc=%0d got=%0h/%0h exp=%0h", cyc, bus.o_bm0, bus.o_bm1, pk(2,1,1,0,0,0,0,0)); end
            end
            exp_cnt = (n_out > 255) ? 8'd255 : 8'(n_out);
            checks++; if (bus.o_pair_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.o_pair_cnt, exp_cnt); end
        end
        checks++; if (n_out != 300) begin failures++; $display("FAIL sat_pairs got=%0d exp=300", n_out); end
        checks++; if (bus.o_pair_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", bus.o_pair_cnt); end
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        start_frame(`CODE_RATE_3);
        bus.i_valid = 1'b1; bus.i_rx = 6'b000_011;
        tick();
        bus.i_valid = 1'b0;
        tick();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL mr_first got=%0b exp=1", bus.o_valid); end
        bus.i_valid = 1'b1; bus.i_rx = 6'b111_111;
        tick();
        bus.i_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%0b exp=0", bus.o_valid); end
        checks++; if (bus.o_bm0 !== 16'h0) begin failures++; $display("FAIL mr_bm0 got=%0h exp=0", bus.o_bm0); end
        checks++; if (bus.o_pair_cnt !== 8'd0) begin failures++; $display("FAIL mr_cnt got=%0d exp=0", bus.o_pair_cnt); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL mr_state got=%0d exp=0", dbg_state); end
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin failures++; $display("FAIL mr_flush i=%0d got=%0b%0b exp=00", i, bus.o_valid, bus.o_last); end
        end
        checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL mr_rerun got=%0d exp=1", dbg_state); end
        bus.i_valid = 1'b1; bus.i_rx = 6'b000_011;
        tick();
        bus.i_valid = 1'b0;
        tick();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL mr_new got=%0b exp=1", bus.o_valid); end
        checks++; if (bus.o_bm0 !== pk(2,1,1,0,3,2,2,1)) begin failures++; $display("FAIL mr_bm0_new got=%0h exp=%0h", bus.o_bm0, pk(2,1,1,0,3,2,2,1)); end
        checks++; if (bus.o_pair_cnt !== 8'd1) begin failures++; $display("FAIL mr_cnt_new got=%0d exp=1", bus.o_pair_cnt); end
        end_frame();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rate2();
        test_rate3();
        test_back_to_back();
        test_toggle_saturate();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
